// File: rtl/vmem_lsu_if.sv
// Request/response handshake bundle between the vector register file side
// and the banked load/store unit.
interface vmem_lsu_if #(
  parameter int unsigned LANES  = 16,
  parameter int unsigned DATA_W = 16,
  parameter int unsigned ADDR_W = 10
);
  logic                    req_valid;
  logic                    req_ready;
  logic                    req_store;
  logic [ADDR_W-1:0]       req_base;
  logic [ADDR_W-1:0]       req_stride;
  logic [LANES-1:0]        req_mask;
  logic [LANES*DATA_W-1:0] req_wdata;
  logic                    resp_valid;
  logic                    resp_ready;
  logic                    resp_store;
  logic [LANES*DATA_W-1:0] resp_rdata;

  modport master (
    output req_valid, req_store, req_base, req_stride, req_mask, req_wdata, resp_ready,
    input  req_ready, resp_valid, resp_store, resp_rdata
  );

  modport slave (
    input  req_valid, req_store, req_base, req_stride, req_mask, req_wdata, resp_ready,
    output req_ready, resp_valid, resp_store, resp_rdata
  );
endinterface

// File: rtl/vmem_lsu.sv
// Banked strided vector load/store unit. One vector request in flight; lanes
// that map to the same bank are serialised, lowest lane first.
// Optional VMEM_LSU_PERF_EN adds request / bank-conflict counters.
module vmem_lsu #(
  parameter int unsigned LANES  = 16,
  parameter int unsigned DATA_W = 16,
  parameter int unsigned ADDR_W = 10,
  parameter int unsigned BANKS  = 16
) (
  input  logic        clk,
  input  logic        rst,
  vmem_lsu_if.slave   bus
`ifdef VMEM_LSU_PERF_EN
  ,
  output logic [31:0] perf_reqs,
  output logic [31:0] perf_conflicts
`endif
);

  localparam int unsigned LANE_W = (LANES > 1) ? $clog2(LANES) : 1;
  localparam int unsigned BANK_W = (BANKS > 1) ? $clog2(BANKS) : 1;
  localparam int unsigned ROWS   = (1 << ADDR_W) / BANKS;
  localparam int unsigned ROW_W  = (ROWS > 1) ? $clog2(ROWS) : 1;

  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, RESP} state_t;

  state_t                         state_q;
  logic                           req_ready_q;
  logic                           resp_valid_q;
  logic                           resp_store_q;
  logic [LANES-1:0][DATA_W-1:0]   rdata_q;
  logic                           store_q;
  logic [ADDR_W-1:0]              base_q;
  logic [ADDR_W-1:0]              stride_q;
  logic [LANES-1:0][DATA_W-1:0]   wdata_q;
  logic [LANES-1:0]               pending_q;

  logic [DATA_W-1:0]              mem_q [BANKS][ROWS];
  logic [BANKS-1:0]               rd_vld_q;
  logic [BANKS-1:0][LANE_W-1:0]   rd_lane_q;
  logic [BANKS-1:0][DATA_W-1:0]   rd_data_q;

  logic [LANES-1:0][ADDR_W-1:0]   lane_addr;
  logic [LANES-1:0][BANK_W-1:0]   lane_bank;
  logic [LANES-1:0][ROW_W-1:0]    lane_row;
  logic [BANKS-1:0]               sel_vld;
  logic [BANKS-1:0][LANE_W-1:0]   sel_lane;
  logic [BANKS-1:0][ROW_W-1:0]    sel_row;
  logic [LANES-1:0]               served;
  logic                           issuing;

`ifdef VMEM_LSU_PERF_EN
  logic [31:0] perf_reqs_q;
  logic [31:0] perf_conflicts_q;
  logic        first_q;
  assign perf_reqs      = perf_reqs_q;
  assign perf_conflicts = perf_conflicts_q;
`endif

  // Ready is held in the register as the IDLE value; reset forces it low.
  assign bus.req_ready  = req_ready_q & ~rst;
  assign bus.resp_valid = resp_valid_q;
  assign bus.resp_store = resp_store_q;
  assign bus.resp_rdata = rdata_q;
  assign issuing        = (state_q == ISSUE);

  // Per-lane word address, bank and row (address arithmetic wraps at 2^ADDR_W).
  always_comb begin
    lane_addr = '0;
    lane_bank = '0;
    lane_row  = '0;
    for (int i = 0; i < LANES; i++) begin
      lane_addr[i] = base_q + ADDR_W'(i) * stride_q;
      lane_bank[i] = BANK_W'(32'(lane_addr[i]) % BANKS);
      lane_row[i]  = ROW_W'(32'(lane_addr[i]) / BANKS);
    end
  end

  // Each bank picks its lowest-numbered pending lane this cycle.
  always_comb begin
    sel_vld  = '0;
    sel_lane = '0;
    sel_row  = '0;
    served   = '0;
    for (int b = 0; b < BANKS; b++) begin
      for (int i = LANES - 1; i >= 0; i--) begin
        if (pending_q[i] && (lane_bank[i] == BANK_W'(b))) begin
          sel_vld[b]  = 1'b1;
          sel_lane[b] = LANE_W'(i);
          sel_row[b]  = lane_row[i];
        end
      end
    end
    for (int b = 0; b < BANKS; b++) begin
      if (sel_vld[b]) served[sel_lane[b]] = 1'b1;
    end
  end

  // Bank arrays: one access per bank per issue cycle, registered read data.
  always_ff @(posedge clk) begin
    for (int b = 0; b < BANKS; b++) begin
      if (!rst && issuing && sel_vld[b]) begin
        if (store_q) mem_q[b][sel_row[b]] <= wdata_q[sel_lane[b]];
        rd_data_q[b] <= mem_q[b][sel_row[b]];
        rd_lane_q[b] <= sel_lane[b];
      end
    end
  end

  // Control FSM, response register and read-data capture.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      req_ready_q  <= 1'b1;
      resp_valid_q <= 1'b0;
      resp_store_q <= 1'b0;
      rdata_q      <= '0;
      store_q      <= 1'b0;
      base_q       <= '0;
      stride_q     <= '0;
      wdata_q      <= '0;
      pending_q    <= '0;
      rd_vld_q     <= '0;
`ifdef VMEM_LSU_PERF_EN
      perf_reqs_q      <= '0;
      perf_conflicts_q <= '0;
      first_q          <= 1'b0;
`endif
    end else begin
      rd_vld_q <= '0;
      for (int b = 0; b < BANKS; b++) begin
        if (rd_vld_q[b]) rdata_q[rd_lane_q[b]] <= rd_data_q[b];
      end
      case (state_q)
        IDLE: begin
          if (bus.req_valid) begin
            store_q      <= bus.req_store;
            base_q       <= bus.req_base;
            stride_q     <= bus.req_stride;
            wdata_q      <= bus.req_wdata;
            pending_q    <= bus.req_mask;
            resp_store_q <= bus.req_store;
            rdata_q      <= '0;
            req_ready_q  <= 1'b0;
`ifdef VMEM_LSU_PERF_EN
            perf_reqs_q  <= perf_reqs_q + 32'd1;
            first_q      <= 1'b1;
`endif
            if (bus.req_mask == '0) begin
              state_q      <= RESP;
              resp_valid_q <= 1'b1;
            end else begin
              state_q <= ISSUE;
            end
          end
        end
        ISSUE: begin
          pending_q <= pending_q & ~served;
          rd_vld_q  <= store_q ? '0 : sel_vld;
          if ((pending_q & ~served) == '0) state_q <= DRAIN;
`ifdef VMEM_LSU_PERF_EN
          first_q <= 1'b0;
          if (!first_q) perf_conflicts_q <= perf_conflicts_q + 32'd1;
`endif
        end
        DRAIN: begin
          state_q      <= RESP;
          resp_valid_q <= 1'b1;
        end
        RESP: begin
          if (bus.resp_ready) begin
            state_q      <= IDLE;
            resp_valid_q <= 1'b0;
            req_ready_q  <= 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_vmem_lsu.sv
// Bench for vmem_lsu: directed scenarios plus random requests checked against
// a word-addressed memory model and a per-bank occupancy latency model.
module tb_vmem_lsu;
  localparam int unsigned LANES  = 16;
  localparam int unsigned DATA_W = 16;
  localparam int unsigned ADDR_W = 10;
  localparam int unsigned BANKS  = 16;
  localparam int unsigned VW     = LANES * DATA_W;
  localparam int unsigned MEMW   = 1 << ADDR_W;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  vmem_lsu_if #(.LANES(LANES), .DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus();

`ifdef VMEM_LSU_PERF_EN
  logic [31:0] perf_reqs;
  logic [31:0] perf_conflicts;
`endif

  vmem_lsu #(.LANES(LANES), .DATA_W(DATA_W), .ADDR_W(ADDR_W), .BANKS(BANKS)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
`ifdef VMEM_LSU_PERF_EN
    ,
    .perf_reqs(perf_reqs),
    .perf_conflicts(perf_conflicts)
`endif
  );

  int checks = 0;
  int failures = 0;
  logic [DATA_W-1:0] mm [MEMW];

  task automatic chk(input string name, input logic [VW-1:0] act, input logic [VW-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  function automatic int unsigned laddr(input logic [ADDR_W-1:0] base,
                                        input logic [ADDR_W-1:0] stride, input int i);
    return (int'(base) + i * int'(stride)) % MEMW;
  endfunction

  // Issue one request, check latency, response fields and hold behaviour.
  task automatic do_req(input bit st, input logic [ADDR_W-1:0] base,
                        input logic [ADDR_W-1:0] stride, input logic [LANES-1:0] mask,
                        input logic [VW-1:0] wdata, input int hold,
                        output logic [VW-1:0] got);
    int cnt [BANKS];
    int k;
    int exp_lat;
    int c;
    int unsigned a;
    logic [VW-1:0] exp;
    exp = '0;
    k = 0;
    for (int b = 0; b < BANKS; b++) cnt[b] = 0;
    for (int i = 0; i < LANES; i++) begin
      if (mask[i]) begin
        a = laddr(base, stride, i);
        cnt[a % BANKS]++;
        if (st) mm[a] = wdata[i*DATA_W +: DATA_W];
        else    exp[i*DATA_W +: DATA_W] = mm[a];
      end
    end
    for (int b = 0; b < BANKS; b++) if (cnt[b] > k) k = cnt[b];
    exp_lat = (mask == '0) ? 1 : k + 2;

    for (int w = 0; w < 50 && !bus.req_ready; w++) @(negedge clk);
    chk("req_ready_idle", VW'(bus.req_ready), VW'(1));
    bus.req_valid  = 1'b1;
    bus.req_store  = st;
    bus.req_base   = base;
    bus.req_stride = stride;
    bus.req_mask   = mask;
    bus.req_wdata  = wdata;
    bus.resp_ready = (hold == 0);
    @(posedge clk);
    @(negedge clk);
    bus.req_valid = 1'b0;
    c = 1;
    while (!bus.resp_valid && c < 100) begin
      chk("req_ready_busy", VW'(bus.req_ready), VW'(0));
      @(negedge clk);
      c++;
    end
    chk("latency", VW'(c), VW'(exp_lat));
    chk("resp_store", VW'(bus.resp_store), VW'(st));
    chk("resp_rdata", bus.resp_rdata, exp);
    got = bus.resp_rdata;
    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      chk("hold_valid", VW'(bus.resp_valid), VW'(1));
      chk("hold_rdata", bus.resp_rdata, exp);
      chk("hold_ready", VW'(bus.req_ready), VW'(0));
    end
    bus.resp_ready = 1'b1;
    @(negedge clk);
    chk("done_valid", VW'(bus.resp_valid), VW'(0));
    chk("done_ready", VW'(bus.req_ready), VW'(1));
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [VW-1:0] wd;
    logic [VW-1:0] got;
    logic [VW-1:0] lit;
    logic [ADDR_W-1:0] stride;
    logic [LANES-1:0] mask;
`ifdef VMEM_LSU_PERF_EN
    logic [31:0] pr0;
    logic [31:0] pc0;
`endif

    rst = 1'b1;
    bus.req_valid  = 1'b0;
    bus.req_store  = 1'b0;
    bus.req_base   = '0;
    bus.req_stride = '0;
    bus.req_mask   = '0;
    bus.req_wdata  = '0;
    bus.resp_ready = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_req_ready", VW'(bus.req_ready), VW'(0));
    chk("rst_resp_valid", VW'(bus.resp_valid), VW'(0));
    chk("rst_resp_store", VW'(bus.resp_store), VW'(0));
    chk("rst_resp_rdata", bus.resp_rdata, '0);
    rst = 1'b0;
    #1;
    chk("post_rst_ready", VW'(bus.req_ready), VW'(1));

    // Fill the whole memory so the model knows every word.
    for (int j = 0; j < int'(MEMW / LANES); j++) begin
      for (int i = 0; i < LANES; i++) wd[i*DATA_W +: DATA_W] = DATA_W'($urandom);
      do_req(1'b1, ADDR_W'(j * LANES), ADDR_W'(1), '1, wd, 0, got);
    end

    // Unit-stride store then load at base 0.
    for (int i = 0; i < LANES; i++) wd[i*DATA_W +: DATA_W] = DATA_W'(16'h1000 + i);
    do_req(1'b1, '0, ADDR_W'(1), '1, wd, 0, got);
    do_req(1'b0, '0, ADDR_W'(1), '1, '0, 0, got);
    for (int i = 0; i < LANES; i++) lit[i*DATA_W +: DATA_W] = DATA_W'(16'h1000 + i);
    chk("unit_load_literal", got, lit);

    // Every lane in bank 5: fully serialised.
`ifdef VMEM_LSU_PERF_EN
    pr0 = perf_reqs;
    pc0 = perf_conflicts;
`endif
    do_req(1'b0, ADDR_W'(5), ADDR_W'(16), '1, '0, 0, got);
`ifdef VMEM_LSU_PERF_EN
    chk("perf_conflicts_delta", VW'(perf_conflicts - pc0), VW'(15));
    chk("perf_reqs_delta", VW'(perf_reqs - pr0), VW'(1));
`endif

    // Stride 0: highest lane wins.
    for (int i = 0; i < LANES; i++) wd[i*DATA_W +: DATA_W] = DATA_W'(i);
    do_req(1'b1, ADDR_W'(7), '0, '1, wd, 0, got);
    do_req(1'b0, ADDR_W'(7), ADDR_W'(1), LANES'(1), '0, 0, got);
    chk("stride0_literal", got, VW'(15));

    // Partial mask and empty mask.
    do_req(1'b0, ADDR_W'(100), ADDR_W'(1), LANES'(16'h00F0), '0, 0, got);
    lit = '0;
    for (int i = 4; i < 8; i++) lit[i*DATA_W +: DATA_W] = {DATA_W{1'b1}};
    chk("mask_zero_lanes", got & ~lit, '0);
    do_req(1'b0, ADDR_W'(100), ADDR_W'(1), '0, '0, 0, got);
    chk("mask0_literal", got, '0);

    // Address wrap, response held off for 5 cycles.
    for (int i = 0; i < LANES; i++) wd[i*DATA_W +: DATA_W] = DATA_W'(16'h2000 + i);
    do_req(1'b1, ADDR_W'(10'h3FE), ADDR_W'(1), '1, wd, 0, got);
    do_req(1'b0, '0, ADDR_W'(1), '1, '0, 5, got);
    chk("wrap_lane0", VW'(got[0 +: DATA_W]), VW'(16'h2002));
    chk("wrap_lane13", VW'(got[13*DATA_W +: DATA_W]), VW'(16'h200F));

    // Reset after three issue cycles of a stride-16 store.
    for (int i = 0; i < LANES; i++) wd[i*DATA_W +: DATA_W] = DATA_W'($urandom);
    bus.req_valid  = 1'b1;
    bus.req_store  = 1'b1;
    bus.req_base   = ADDR_W'(3);
    bus.req_stride = ADDR_W'(16);
    bus.req_mask   = '1;
    bus.req_wdata  = wd;
    @(posedge clk);
    @(negedge clk);
    bus.req_valid = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("midrst_ready", VW'(bus.req_ready), VW'(1));
    chk("midrst_valid", VW'(bus.resp_valid), VW'(0));
    for (int i = 0; i < 3; i++) mm[laddr(ADDR_W'(3), ADDR_W'(16), i)] = wd[i*DATA_W +: DATA_W];
    do_req(1'b0, ADDR_W'(3), ADDR_W'(16), '1, '0, 0, got);

    // Random requests.
    for (int n = 0; n < 60; n++) begin
      case ($urandom_range(0, 5))
        0: stride = ADDR_W'(1);
        1: stride = ADDR_W'(16);
        2: stride = '0;
        3: stride = '1;
        4: stride = ADDR_W'(2);
        default: stride = ADDR_W'($urandom);
      endcase
      case ($urandom_range(0, 9))
        0: mask = '0;
        1, 2: mask = '1;
        default: mask = LANES'($urandom);
      endcase
      for (int i = 0; i < LANES; i++) wd[i*DATA_W +: DATA_W] = DATA_W'($urandom);
      do_req(1'($urandom_range(0, 1)), ADDR_W'($urandom), stride, mask, wd,
             int'($urandom_range(0, 3)), got);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/vmem_lsu.md
# vmem_lsu

Parametrised banked vector load/store unit: executes one strided vector load or store of up to LANES elements against BANKS single-ported word memories and resolves bank conflicts by serialising them. It sits between the vector register file (256-bit vectors at defaults) and the banked data memory, replacing per-bank hand-wired instances with one generated array. Requests and responses use valid/ready handshakes.

## Interface
- LANES, 16, elements per vector
- DATA_W, 16, element width in bits
- ADDR_W, 10, word-address width; total memory is 2^ADDR_W words
- BANKS, 16, bank count, power of two, ≤ 2^ADDR_W; each bank holds 2^ADDR_W/BANKS words

- clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- req_valid  in  1  request present
- req_ready  out  1  unit can accept (high only in IDLE)
- req_store  in  1  1 = store, 0 = load
- req_base  in  ADDR_W  word address of lane 0
- req_stride  in  ADDR_W  word stride, two's complement
- req_mask  in  LANES  lane enables
- req_wdata  in  LANES*DATA_W  store data, lane i at [i*DATA_W +: DATA_W]
- resp_valid  out  1  response present
- resp_ready  in  1  consumer accepts response
- resp_store  out  1  echo of req_store
- resp_rdata  out  LANES*DATA_W  load data, same lane packing

## Operation
- Lane address: addr_i = (base + i*stride) mod 2^ADDR_W; bank = addr_i mod BANKS; row = addr_i / BANKS.
- FSM states: IDLE, ISSUE, DRAIN, RESP.
- IDLE: req_ready=1. On req_valid: latch all request fields, pending = mask, clear resp_rdata; go ISSUE, or RESP directly if mask is all zero (no memory access).
- ISSUE: each bank serves the lowest-numbered pending lane mapped to it (one access per bank per cycle); served lanes leave pending. When pending becomes empty after this cycle's issue, go DRAIN.
- Loads: bank read data of lane i is written into resp_rdata lane i one cycle after issue. Masked-off lanes read 0.
- Stores: write in the issue cycle. Lanes hitting the same address are ordered by lane number; the highest lane's data wins. resp_rdata is all zero for stores.
- DRAIN: one cycle to capture the final reads (taken for stores too); go RESP.
- RESP: resp_valid=1; fields held stable until resp_ready; then go IDLE.
- Memory contents are not reset.

## Timing
- Reset values: req_ready=0 while rst is high, then 1 (IDLE); resp_valid=0; resp_store=0; resp_rdata=0.
- Accept edge = cycle 0. ISSUE occupies cycles 1..K, where K = max active lanes sharing one bank. DRAIN is cycle K+1. resp_valid rises in cycle K+2.
- Unit-stride with LANES ≤ BANKS gives K=1 and resp_valid in cycle 3. An all-zero mask gives resp_valid in cycle 1.
- With resp_ready held high, resp_valid lasts one cycle and the next request can be accepted one cycle later. Throughput is non-pipelined: one request in flight.
- rst mid-operation: next state is IDLE and pending is cleared. Stores already issued remain in memory; unissued lanes are dropped.
- Bank read latency is 1 cycle. A read and write to the same bank never occur in the same cycle because only one access is issued per bank.

## Configuration
- VMEM_LSU_PERF_EN defined: adds output perf_reqs [31:0], which counts accepted requests, and output perf_conflicts [31:0], which counts ISSUE cycles beyond the first per request. Both reset to 0, wrap at 2^32, and hold their values during RESP.
- Not defined: neither port nor the counters exist; behaviour is otherwise identical.

## Test plan
- Unit-stride store, base 0, data lane i = 0x1000+i, full mask, then load with base 0 → resp_rdata lane i = 0x1000+i; resp_valid in cycle 3 for each request.
- Load with stride 16, base 5 (all lanes in bank 5) → K=16, resp_valid in cycle 18, data correct; perf_conflicts increases by 15 when VMEM_LSU_PERF_EN is defined.
- Store with stride 0, base 7, data lane i = i → a later load of address 7 returns 15 (highest lane wins).
- Load with mask 0x00F0 → lanes 4..7 hold data and all other lanes are 0. Mask 0 → resp_valid in cycle 1 with all-zero data.
- Base 0x3FE, stride 1 → lanes 2..15 wrap to addresses 0..13. Hold resp_ready low 5 cycles → resp_valid and resp_rdata stay stable and req_ready stays 0.
- Assert rst during ISSUE of a stride-16 store → req_ready=1 and resp_valid=0 on the next cycle. Only lanes issued before the reset are visible in a subsequent load.
